// File: rtl/mem_sram_slave_if.sv
// Request/response bundle between the memory arbiter and the SRAM slave.
//
// Handshake: the master raises PSEL with a stable PADDR/HWRITE/PDATA/PSTRB.
// The request is taken on a rising edge where PSEL=1 and the slave is
// either idle (busy=0) or in its response cycle (PREADY=1). PSEL seen at
// any other time is ignored, so the master keeps presenting the request
// until it is taken. Each taken request yields exactly one PREADY pulse.
// PRDATA and PSLVERR are meaningful only while PREADY=1.
`timescale 1ns/1ps
interface mem_sram_slave_if;
  logic        PSEL;
  logic [63:0] PADDR;
  logic        HWRITE;
  logic [63:0] PDATA;
  logic [7:0]  PSTRB;
  logic [63:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
  logic        busy;

  modport master (
    output PSEL, PADDR, HWRITE, PDATA, PSTRB,
    input  PRDATA, PREADY, PSLVERR, busy
  );

  modport slave (
    input  PSEL, PADDR, HWRITE, PDATA, PSTRB,
    output PRDATA, PREADY, PSLVERR, busy
  );
endinterface

// File: rtl/mem_sram_slave.sv
// Single-request SRAM slave: latches one arbitrated request, waits a fixed
// number of cycles, then performs a byte-strobed write or a full-word read
// against a 64-bit-wide synchronous array and signals completion with a
// one-cycle PREADY pulse.
`timescale 1ns/1ps
module mem_sram_slave #(
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int WAIT_STATES    = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  mem_sram_slave_if.slave  bus,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEPTH = 1 << MEM_DEPTH_LOG2;

  state_t                    state;
  logic [3:0]                cnt;
  logic [MEM_DEPTH_LOG2-1:0] idx_q;
  logic                      oor_q;
  logic                      wr_q;
  logic [63:0]               data_q;
  logic [7:0]                strb_q;

  logic [63:0] mem [DEPTH];

  logic accept;
  logic commit;
  logic unused_paddr_lo;

  // A new request is taken when idle or overlapping the response cycle.
  assign accept = bus.PSEL && ((state == IDLE) || (state == RESP));
  // The array is touched on the edge where the wait counter has run out.
  assign commit = (state == ACCESS) && (cnt == 4'd0);

  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

  // Byte offset inside the word is irrelevant; lanes are chosen by PSTRB.
  assign unused_paddr_lo = &{1'b0, bus.PADDR[2:0]};

  // Control FSM with latched request copy and registered response outputs.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      idx_q       <= '0;
      oor_q       <= 1'b0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      strb_q      <= '0;
      bus.PREADY  <= 1'b0;
      bus.PSLVERR <= 1'b0;
      bus.PRDATA  <= '0;
    end else begin
      if (accept) begin
        idx_q  <= bus.PADDR[MEM_DEPTH_LOG2+2:3];
        oor_q  <= |bus.PADDR[63:MEM_DEPTH_LOG2+3];
        wr_q   <= bus.HWRITE;
        data_q <= bus.PDATA;
        strb_q <= bus.PSTRB;
        cnt    <= 4'(WAIT_STATES);
      end
      case (state)
        IDLE: begin
          if (bus.PSEL) state <= ACCESS;
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state       <= RESP;
            bus.PREADY  <= 1'b1;
            bus.PSLVERR <= oor_q;
            if (oor_q)      bus.PRDATA <= '0;
            else if (!wr_q) bus.PRDATA <= mem[idx_q];
          end
        end
        RESP: begin
          bus.PREADY  <= 1'b0;
          bus.PSLVERR <= 1'b0;
          state       <= bus.PSEL ? ACCESS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write port: only in-range writes, only strobed byte lanes.
  always_ff @(posedge HCLK) begin
    if (commit && wr_q && !oor_q) begin
      for (int i = 0; i < 8; i++) begin
        if (strb_q[i]) mem[idx_q][8*i +: 8] <= data_q[8*i +: 8];
      end
    end
  end

endmodule
